// File: rtl/add_sub_pipe_elastic_pkg.sv
// Shared sizing helpers and operation encoding for the segmented add/sub pipe.
package add_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int div_up(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Bits per carry segment.
  function automatic int seg_w(input int width, input int stages);
    return div_up(width, stages);
  endfunction

  // Padded datapath width: whole segments, operands zero-extended to this.
  function automatic int pad_w(input int width, input int stages);
    return stages * div_up(width, stages);
  endfunction

endpackage

// File: rtl/add_seg_stage.sv
// One carry segment: adds segment POS of the running word with B's low
// segment plus the incoming carry, then registers the result behind an
// elastic valid/run slice. The running word x holds finished sum segments
// below POS and untouched A segments above it, so it stays a fixed PW wide;
// B shrinks by one segment per stage.
module add_seg_stage
  import add_pipe_pkg::*;
#(
  parameter int  SEG     = 85,
  parameter int  UPPER_W = 0,
  parameter int  TAG_W   = 8,
  parameter int  PW      = 765,
  parameter int  POS     = 0,
  localparam int BO_W    = (UPPER_W > 0) ? UPPER_W : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   valid_i,
  output logic                   valid_o,
  input  logic [PW-1:0]          x_i,
  output logic [PW-1:0]          x_o,
  input  logic [SEG+UPPER_W-1:0] b_i,
  output logic [BO_W-1:0]        b_o,
  input  logic                   c_i,
  output logic                   c_o,
  input  logic                   sub_i,
  output logic                   sub_o,
  input  logic [TAG_W-1:0]       tag_i,
  output logic [TAG_W-1:0]       tag_o
);

  logic [SEG:0]  seg_sum;
  logic [PW-1:0] x_nx;

  // Segment adder; the sum replaces this segment's A bits in the running word.
  always_comb begin
    seg_sum = {1'b0, x_i[POS*SEG +: SEG]} + {1'b0, b_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};
    x_nx    = x_i;
    x_nx[POS*SEG +: SEG] = seg_sum[SEG-1:0];
  end

  // Valid bit: only this bit is reset, so a reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst)      valid_o <= 1'b0;
    else if (run) valid_o <= valid_i;
  end

  // Payload: loads only with a real transaction, holds while stalled.
  always_ff @(posedge clk) begin
    if (run && valid_i) begin
      x_o   <= x_nx;
      c_o   <= seg_sum[SEG];
      sub_o <= sub_i;
      tag_o <= tag_i;
    end
  end

  if (UPPER_W > 0) begin : g_fwd
    // Forward the not-yet-added B segments.
    always_ff @(posedge clk) begin
      if (run && valid_i) b_o <= b_i[SEG+UPPER_W-1:SEG];
    end
  end else begin : g_last
    assign b_o = 1'b0;
  end

endmodule

// File: rtl/add_sub_pipe_elastic.sv
// WIDTH-bit add/sub split into STAGES carry segments, one segment per
// register stage, with a bubble-collapsing valid/run chain on both sides.
module add_sub_pipe_elastic
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 757,
  parameter int STAGES = 9,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_co,
  output logic [TAG_W-1:0] out_tag,
  output logic             idle
);

  localparam int SEG = seg_w(WIDTH, STAGES);
  localparam int PW  = pad_w(WIDTH, STAGES);

  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0]             run_s;
  logic [STAGES:0]             c_s;
  logic [STAGES:0]             sub_s;
  logic [STAGES:0][PW-1:0]     x_s;
  logic [STAGES:0][PW-1:0]     b_s;
  logic [STAGES:0][TAG_W-1:0]  tag_s;
  logic [WIDTH-1:0]            b_cond;
  op_e                         op;
  logic                        s_top;
  logic                        unused_tail;

  assign op = op_e'(in_sub);

  // Subtract as A + ~B + !bin; inversion stays inside WIDTH so pad bits stay 0.
  always_comb begin
    b_cond = (op == OP_SUB) ? ~in_b : in_b;
  end

  assign vld_pipe[0] = in_valid;
  assign x_s[0]      = PW'(in_a);
  assign b_s[0]      = PW'(b_cond);
  assign c_s[0]      = (op == OP_SUB) ? !in_cin : in_cin;
  assign sub_s[0]    = in_sub;
  assign tag_s[0]    = in_tag;

  // Run chain: a stage advances when it is empty or the stage after it advances.
  always_comb begin
    run_s         = '0;
    run_s[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      run_s[k] = !vld_pipe[k+1] || run_s[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int UP = (STAGES - 1 - k) * SEG;
    localparam int BO = (UP > 0) ? UP : 1;
    logic [BO-1:0] b_nx;

    add_seg_stage #(
      .SEG    (SEG),
      .UPPER_W(UP),
      .TAG_W  (TAG_W),
      .PW     (PW),
      .POS    (k)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .run    (run_s[k]),
      .valid_i(vld_pipe[k]),
      .valid_o(vld_pipe[k+1]),
      .x_i    (x_s[k]),
      .x_o    (x_s[k+1]),
      .b_i    (b_s[k][SEG+UP-1:0]),
      .b_o    (b_nx),
      .c_i    (c_s[k]),
      .c_o    (c_s[k+1]),
      .sub_i  (sub_s[k]),
      .sub_o  (sub_s[k+1]),
      .tag_i  (tag_s[k]),
      .tag_o  (tag_s[k+1])
    );

    assign b_s[k+1] = PW'(b_nx);

    // Consumed B segments above the live slice carry nothing.
    if (k > 0) begin : g_sink
      logic unused_b_hi;
      assign unused_b_hi = ^b_s[k][PW-1:SEG+UP];
    end
  end

  // S[WIDTH] is a pad bit of the sum when padded, else the top segment's carry.
  if (PW > WIDTH) begin : g_pad
    assign s_top = x_s[STAGES][WIDTH];
  end else begin : g_nopad
    assign s_top = c_s[STAGES];
  end

  assign out_valid   = vld_pipe[STAGES];
  assign out_data    = x_s[STAGES][WIDTH-1:0];
  assign out_co      = sub_s[STAGES] ? !s_top : s_top;
  assign out_tag     = tag_s[STAGES];
  assign in_ready    = run_s[0];
  assign idle        = !(in_valid || (|vld_pipe[STAGES:1]));
  assign unused_tail = ^{b_s[STAGES], x_s[STAGES], c_s[STAGES]};

endmodule

// File: doc/add_sub_pipe_elastic.md
Name: add_sub_pipe_elastic

Overview:
- Parametrised successor to the fixed 9-segment carry-split adder used in the MSM field-arithmetic datapath.
- Adds or subtracts two WIDTH-bit operands through STAGES register stages. The carry ripples one segment per stage.
- Supports per-transaction add/sub, carry/borrow-in, carry/borrow-out and a sideband tag.
- Uses a proper valid/ready handshake on both sides, with bubble-collapsing per-stage stall, in place of the old select-driven last stage.

Parameters:
- WIDTH, 757, operand/result width in bits.
- STAGES, 9, number of pipeline stages and carry segments, 1..16.
- TAG_W, 8, sideband tag width carried alongside each transaction, >=1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  stage 1 can accept this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B+cin; 1 = A-B-bin.
- in_cin  in  1  carry-in (add) or borrow-in (sub).
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  result mod 2^WIDTH.
- out_co  out  1  carry-out (add) or borrow-out (sub).
- out_tag  out  TAG_W  tag of the result.
- idle  out  1  no transaction at the input or in flight.

Behaviour:
- Segmentation:
  - SEG = DIV_UP(WIDTH, STAGES); PW = STAGES*SEG. Operands are zero-extended to PW.
  - Segment k occupies bits [k*SEG +: SEG].
- Operand conditioning (before padding):
  - B' = in_sub ? ~in_b : in_b, inverted over WIDTH bits only; pad bits are always 0.
  - c0 = in_sub ? !in_cin : in_cin.
- Arithmetic: the pipeline computes S = A + B' + c0 over WIDTH+1 bits.
  - out_data = S[WIDTH-1:0].
  - out_co = in_sub ? !S[WIDTH] : S[WIDTH].
  - This must hold whether PW > WIDTH (carry lands in a pad bit) or PW == WIDTH (carry is the top segment's carry-out).
- Stage k (k=0..STAGES-1):
  - Adds segment k plus the registered carry from stage k-1; stage 0 uses c0.
  - Registers its sum segment and the carry, forwards the not-yet-added upper operand segments, and forwards in_sub and the tag.
  - Lower sum segments shift forward unchanged.
- Latency: exactly STAGES cycles from accept (in_valid & in_ready) to out_valid with no stall. Throughput is 1 per cycle.
- Handshake:
  - Stage n register = valid_n. run_n = !(valid_n & !run_{n+1}); run for the last stage = out_ready.
  - in_ready = run_1.
  - A stage loads when its run is 1 and holds otherwise. valid_n <= run_{n-1} ? valid_{n-1} : valid_n.
  - Bubbles collapse: a stalled downstream does not stop upper stages holding bubbles from advancing.
  - out_valid = valid_STAGES. Outputs are stable while out_valid & !out_ready.
  - The pipeline holds at most STAGES transactions.
- Simultaneous events:
  - Accept and drain in the same cycle on a full pipe is legal, with no bubble inserted.
  - in_valid while !in_ready: the input is not taken; the source must hold.
- Reset:
  - All valid_n = 0, so out_valid = 0, in_ready = 1 and idle = 1 in the cycle after rst is sampled high.
  - Data/tag registers are not reset; out_data/out_co/out_tag are checked only when out_valid = 1.
  - Reset mid-operation discards all in-flight transactions; no stale result ever appears.
- idle = !(in_valid | any valid_n).
- No combinational path from out_ready to in_ready beyond the run chain; no path from in_* to out_*.

Decomposition:
- Package add_pipe_pkg holds:
  - function div_up;
  - localparam derivation helpers for SEG/PW;
  - typedef op_e {OP_ADD, OP_SUB}.
- Sub-module add_seg_stage: one segment adder plus register slice, with parameters SEG, UPPER_W, TAG_W and ports run/valid in/out.
- The top generates STAGES instances and the run chain.

Test Plan:
- Defaults: add, A = 2^757-1, B = 1, cin = 0 -> after 9 cycles out_data = 0, out_co = 1, tag echoed.
- Sub: A = 5, B = 7, bin = 0 -> out_data = 2^757-2, out_co = 1. Then A = 7, B = 5 -> out_data = 2, out_co = 0. Then A = 7, B = 5, bin = 1 -> out_data = 1.
- Stream 1000 random add/sub with random tags, out_ready = 1 -> one result per cycle after a 9-cycle fill; data, co, tag and order match the reference model.
- Stream with out_ready = 0 for 20 cycles -> in_ready falls after 9 accepts, zero loss or duplication. Then out_ready toggles randomly 50% -> model still matches.
- rst asserted for 1 cycle with 5 transactions in flight -> next cycle out_valid = 0, idle = 1; no result from those 5 ever emerges.
- WIDTH = 64, STAGES = 4 (and STAGES = 1; and WIDTH = 63, STAGES = 4 for padding): A = 0x0000_FFFF_FFFF_FFFF, B = 1 -> out_data = 0x0001_0000_0000_0000, out_co = 0. Then A = 2^64-1, B = 1 -> 0, co = 1.
